// File: rtl/lock_clear_ctrl_pkg.sv
// Shared playfield types, scoring constants and FSM state encoding for the
// lock/clear controller and its score calculator.
package lock_clear_ctrl_pkg;

    localparam int FIELD_VERTICAL   = 22;
    localparam int FIELD_HORIZONTAL = 10;
    localparam int CELL_W           = 3;

    typedef logic [CELL_W-1:0]            cell_t;
    typedef cell_t [FIELD_HORIZONTAL-1:0] row_t;
    typedef row_t  [FIELD_VERTICAL-1:0]   field_t;   // row 0 is the top row

    localparam cell_t  TETROMINO_EMPTY = 3'd0;
    localparam field_t FIELD_EMPTY     = {(FIELD_VERTICAL*FIELD_HORIZONTAL){TETROMINO_EMPTY}};

    localparam int         BASE_W       = 10;
    localparam logic [9:0] SCORE_BASE_0 = 10'd0;
    localparam logic [9:0] SCORE_BASE_1 = 10'd100;
    localparam logic [9:0] SCORE_BASE_2 = 10'd300;
    localparam logic [9:0] SCORE_BASE_3 = 10'd500;
    localparam logic [9:0] SCORE_BASE_4 = 10'd800;

    typedef enum logic [2:0] {
        LCC_IDLE     = 3'd0,
        LCC_CLEAN    = 3'd1,
        LCC_SCORE    = 3'd2,
        LCC_COMMIT   = 3'd3,
        LCC_GAMEOVER = 3'd4
    } lcc_state_t;

    // Base points for a number of simultaneously cleared lines (0..4).
    function automatic logic [BASE_W-1:0] score_base(input logic [2:0] n);
        logic [BASE_W-1:0] b;
        case (n)
            3'd0:    b = SCORE_BASE_0;
            3'd1:    b = SCORE_BASE_1;
            3'd2:    b = SCORE_BASE_2;
            3'd3:    b = SCORE_BASE_3;
            3'd4:    b = SCORE_BASE_4;
            default: b = SCORE_BASE_0;
        endcase
        return b;
    endfunction

    // True when any cell of the two spawn rows is occupied.
    function automatic logic top_rows_occupied(input field_t f);
        logic occ;
        occ = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < FIELD_HORIZONTAL; c++) begin
                if (f[r][c] != TETROMINO_EMPTY) begin
                    occ = 1'b1;
                end else begin
                    occ = occ;
                end
            end
        end
        return occ;
    endfunction

endpackage

// File: rtl/lock_clear_ctrl_if.sv
// enable/done handshake between the lock/clear controller (master) and the
// clean_field line-clear unit (slave).
interface lock_clear_ctrl_if;
    import lock_clear_ctrl_pkg::*;

    logic       clean_en;
    field_t     clean_f_in;
    field_t     clean_f_out;
    logic [2:0] clean_lines;
    logic       clean_done;

    modport master (
        output clean_en, clean_f_in,
        input  clean_f_out, clean_lines, clean_done
    );

    modport slave (
        input  clean_en, clean_f_in,
        output clean_f_out, clean_lines, clean_done
    );
endinterface

// File: rtl/lock_clear_ctrl_score_calc.sv
// Points for one clear: base[n] * (level + 1); n above 4 is flagged and scores 0.
module lock_clear_ctrl_score_calc
    import lock_clear_ctrl_pkg::*;
#(
    parameter int SCORE_W = 20
) (
    input  logic [2:0]         n,
    input  logic [3:0]         level,
    output logic [SCORE_W-1:0] pts,
    output logic               bad_n
);

    localparam int PROD_W = BASE_W + 5;

    logic [BASE_W-1:0] base_s;
    logic [PROD_W-1:0] prod_s;

    // Select the base value, reject impossible line counts, scale by level.
    always_comb begin
        bad_n  = 1'b0;
        base_s = SCORE_BASE_0;
        if (n > 3'd4) begin
            bad_n  = 1'b1;
            base_s = SCORE_BASE_0;
        end else begin
            bad_n  = 1'b0;
            base_s = score_base(n);
        end
        prod_s = PROD_W'(base_s) * PROD_W'({1'b0, level} + 5'd1);
        pts    = SCORE_W'(prod_s);
    end

endmodule

// File: rtl/lock_clear_ctrl.sv
// Initiator side of the clean_field handshake: captures the merged field on
// a lock pulse, waits for the line clear, scores it and commits the field.
module lock_clear_ctrl
    import lock_clear_ctrl_pkg::*;
#(
    parameter int SCORE_W         = 20,
    parameter int LINES_W         = 10,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int TIMEOUT         = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                new_game,
    input  logic                lock_req,
    input  field_t              f_merged,
    lock_clear_ctrl_if.master   cf,
    output field_t              field_q,
    output logic [SCORE_W-1:0]  score,
    output logic [LINES_W-1:0]  lines_total,
    output logic [3:0]          level,
    output logic                busy,
    output logic                lock_ack,
    output logic                spawn_req,
    output logic                game_over,
    output logic                err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int LIL_W = $clog2(LINES_PER_LEVEL + 8);

    lcc_state_t         state_r, state_next_s;
    logic [TMR_W-1:0]   timer_r;
    logic               timeout_s, top_full_s, bad_n_s;
    field_t             clean_f_in_r, cleaned_r, field_q_r;
    logic [2:0]         lines_r, n_eff_s;
    logic [SCORE_W-1:0] pts_s, score_r, score_next_s;
    logic [SCORE_W:0]   score_sum_s;
    logic [LINES_W-1:0] lines_total_r, lines_next_s;
    logic [LINES_W:0]   lines_sum_s;
    logic [LIL_W-1:0]   lil_r, lil_sum_s, lil_next_s;
    logic [3:0]         level_r, level_next_s;
    logic               clean_en_r, busy_r, lock_ack_r, spawn_req_r, game_over_r, err_r;

    lock_clear_ctrl_score_calc #(.SCORE_W(SCORE_W)) u_score_calc (
        .n     (lines_r),
        .level (level_r),
        .pts   (pts_s),
        .bad_n (bad_n_s)
    );

    assign top_full_s = top_rows_occupied(cleaned_r);

    // State register; new_game overrides everything including lock_req/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LCC_IDLE;
        end else if (new_game) begin
            state_r <= LCC_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic including the clean_done watchdog.
    always_comb begin
        state_next_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            LCC_IDLE: begin
                if (lock_req) state_next_s = LCC_CLEAN;
                else          state_next_s = LCC_IDLE;
            end
            LCC_CLEAN: begin
                if (cf.clean_done) begin
                    state_next_s = LCC_SCORE;
                end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                    state_next_s = LCC_IDLE;
                    timeout_s    = 1'b1;
                end else begin
                    state_next_s = LCC_CLEAN;
                end
            end
            LCC_SCORE:    state_next_s = LCC_COMMIT;
            LCC_COMMIT: begin
                if (top_full_s) state_next_s = LCC_GAMEOVER;
                else            state_next_s = LCC_IDLE;
            end
            LCC_GAMEOVER: state_next_s = LCC_GAMEOVER;
            default:      state_next_s = LCC_IDLE;
        endcase
    end

    // Saturating score/line/level arithmetic applied in the SCORE state.
    always_comb begin
        if (bad_n_s) n_eff_s = 3'd0;
        else         n_eff_s = lines_r;

        score_sum_s = {1'b0, score_r} + {1'b0, pts_s};
        if (score_sum_s[SCORE_W]) score_next_s = {SCORE_W{1'b1}};
        else                      score_next_s = score_sum_s[SCORE_W-1:0];

        lines_sum_s = {1'b0, lines_total_r} + (LINES_W+1)'(n_eff_s);
        if (lines_sum_s[LINES_W]) lines_next_s = {LINES_W{1'b1}};
        else                      lines_next_s = lines_sum_s[LINES_W-1:0];

        lil_sum_s    = lil_r + LIL_W'(n_eff_s);
        level_next_s = level_r;
        if (lil_sum_s >= LIL_W'(LINES_PER_LEVEL)) begin
            lil_next_s = lil_sum_s - LIL_W'(LINES_PER_LEVEL);
            if (level_r < 4'(MAX_LEVEL)) level_next_s = level_r + 4'd1;
            else                         level_next_s = level_r;
        end else begin
            lil_next_s = lil_sum_s;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r       <= '0;
            clean_f_in_r  <= FIELD_EMPTY;
            cleaned_r     <= FIELD_EMPTY;
            field_q_r     <= FIELD_EMPTY;
            lines_r       <= 3'd0;
            score_r       <= '0;
            lines_total_r <= '0;
            lil_r         <= '0;
            level_r       <= 4'd0;
            clean_en_r    <= 1'b0;
            busy_r        <= 1'b0;
            lock_ack_r    <= 1'b0;
            spawn_req_r   <= 1'b0;
            game_over_r   <= 1'b0;
            err_r         <= 1'b0;
        end else if (new_game) begin
            timer_r       <= '0;
            clean_f_in_r  <= FIELD_EMPTY;
            cleaned_r     <= FIELD_EMPTY;
            field_q_r     <= FIELD_EMPTY;
            lines_r       <= 3'd0;
            score_r       <= '0;
            lines_total_r <= '0;
            lil_r         <= '0;
            level_r       <= 4'd0;
            clean_en_r    <= 1'b0;
            busy_r        <= 1'b0;
            lock_ack_r    <= 1'b0;
            spawn_req_r   <= 1'b0;
            game_over_r   <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            clean_en_r  <= (state_next_s == LCC_CLEAN);
            busy_r      <= (state_next_s == LCC_CLEAN) || (state_next_s == LCC_SCORE) ||
                           (state_next_s == LCC_COMMIT);
            lock_ack_r  <= (state_r == LCC_COMMIT);
            spawn_req_r <= (state_r == LCC_COMMIT) && !top_full_s;
            err_r       <= timeout_s || ((state_r == LCC_SCORE) && bad_n_s);

            if (state_r == LCC_CLEAN) timer_r <= timer_r + TMR_W'(1);
            else                      timer_r <= '0;

            if ((state_r == LCC_IDLE) && lock_req) clean_f_in_r <= f_merged;

            if ((state_r == LCC_CLEAN) && cf.clean_done) begin
                cleaned_r <= cf.clean_f_out;
                lines_r   <= cf.clean_lines;
            end

            if (state_r == LCC_SCORE) begin
                score_r       <= score_next_s;
                lines_total_r <= lines_next_s;
                lil_r         <= lil_next_s;
                level_r       <= level_next_s;
            end

            if (state_r == LCC_COMMIT) begin
                field_q_r <= cleaned_r;
                if (top_full_s) game_over_r <= 1'b1;
            end
        end
    end

    assign cf.clean_en   = clean_en_r;
    assign cf.clean_f_in = clean_f_in_r;
    assign field_q       = field_q_r;
    assign score         = score_r;
    assign lines_total   = lines_total_r;
    assign level         = level_r;
    assign busy          = busy_r;
    assign lock_ack      = lock_ack_r;
    assign spawn_req     = spawn_req_r;
    assign game_over     = game_over_r;
    assign err           = err_r;

endmodule
